ngy_grid_probe_display: RTL and testbench

Parametrised probe-to-grid renderer for the ngycore pixel grid. It samples up to NUM_CH packed probe words, such as CPU registers, ALU operands and memory buses, and repaints grid_ram one row per clock on a periodic refresh tick. It adds three things a hard-wired grid assignment lacks: channel paging with the controller keys, a freeze (snapshot-hold) mode, and a frame-complete strobe. It sits between riscv_cpu debug taps and the video path that consumes grid_ram.

---
 rtl/ngy_grid_probe_display.sv | 208 ++++++++++++++++++++
 tb/tb_ngy_grid_probe_display.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ngy_grid_probe_display.sv
// ngy_grid_probe_display
// Renders NUM_CH packed probe words onto a GRID_ROWS x GRID_COLS pixel grid.
// One row is repainted per clock once a refresh tick starts a frame. The
// controller keys page through the channels and freeze the snapshot.
// frame_done pulses for one cycle after the last row of a frame is written.

module ngy_grid_probe_display #(
  parameter int GRID_ROWS   = 30,
  parameter int GRID_COLS   = 40,
  parameter int NUM_CH      = 8,
  parameter int CH_WIDTH    = 32,
  parameter int REFRESH_DIV = 64,
  parameter int PB_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                             clk_74a,
  input  logic                             reset_n,
  input  logic [NUM_CH*CH_WIDTH-1:0]       probe_bus,
  input  logic                             key_up,
  input  logic                             key_down,
  input  logic                             key_freeze,
  output logic [0:GRID_ROWS*GRID_COLS-1]   grid_ram,
  output logic                             frozen,
  output logic [PB_W-1:0]                  page_base,
  output logic                             frame_done
);

  // Highest page_base that still fills every row with a real channel.
  localparam int MAXB = (NUM_CH > GRID_ROWS) ? (NUM_CH - GRID_ROWS) : 0;
  localparam int RW   = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1;
  localparam int CW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int NPIX = GRID_ROWS * GRID_COLS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Registered state and next-state values
  state_t                       state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [RW-1:0]                row_q, row_d;
  logic [PB_W-1:0]              base_lat_q, base_lat_d;
  logic [NUM_CH*CH_WIDTH-1:0]   shadow_q, shadow_d;
  logic [0:NPIX-1]              grid_q, grid_d;
  logic                         frozen_q, frozen_d;
  logic [PB_W-1:0]              page_q, page_d;
  logic                         frame_done_q, frame_done_d;
  logic                         up_prev_q, down_prev_q, frz_prev_q;

  // Combinational helpers
  logic                         tick_s;
  logic                         up_press_s, down_press_s, frz_press_s;
  logic [31:0]                  ch_sum_s;
  logic [CH_WIDTH-1:0]          chan_s;
  logic [0:GRID_COLS-1]         row_data_s;

  assign tick_s       = (cnt_q == CW'(REFRESH_DIV - 1));
  assign up_press_s   = key_up & ~up_prev_q;
  assign down_press_s = key_down & ~down_prev_q;
  assign frz_press_s  = key_freeze & ~frz_prev_q;

  // Free-running refresh divider; wraps on the tick in every FSM state.
  always_comb begin
    cnt_d = cnt_q;
    if (tick_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Key press handling: paging with saturation, freeze toggle.
  always_comb begin
    page_d   = page_q;
    frozen_d = frozen_q;
    if (down_press_s && !up_press_s) begin
      if (int'(page_q) < MAXB) begin
        page_d = page_q + PB_W'(1);
      end else begin
        page_d = page_q;
      end
    end else if (up_press_s && !down_press_s) begin
      if (page_q != '0) begin
        page_d = page_q - PB_W'(1);
      end else begin
        page_d = page_q;
      end
    end else begin
      page_d = page_q;
    end
    if (frz_press_s) begin
      frozen_d = ~frozen_q;
    end else begin
      frozen_d = frozen_q;
    end
  end

  // Frame sequencer: snapshot on tick, one row per clock, then strobe done.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    base_lat_d   = base_lat_q;
    shadow_d     = shadow_q;
    frame_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick_s) begin
          state_d    = ST_SCAN;
          row_d      = '0;
          base_lat_d = page_q;
          // A frozen display keeps repainting the previous snapshot.
          if (!frozen_q) begin
            shadow_d = probe_bus;
          end else begin
            shadow_d = shadow_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (row_q == RW'(GRID_ROWS - 1)) begin
          state_d      = ST_DONE;
          frame_done_d = 1'b1;
        end else begin
          row_d = row_q + RW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pick the channel shown on the current row; rows past the last channel are blank.
  always_comb begin
    ch_sum_s = 32'(base_lat_q) + 32'(row_q);
    chan_s   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_sum_s == 32'(c)) begin
        chan_s = shadow_q[c*CH_WIDTH +: CH_WIDTH];
      end else begin
        chan_s = chan_s;
      end
    end
  end

  // Build the row bitmap: channel MSB first, blank filler, frozen marker on row 0.
  always_comb begin
    row_data_s = '0;
    for (int k = 0; k < CH_WIDTH; k++) begin
      row_data_s[k] = chan_s[CH_WIDTH-1-k];
    end
    row_data_s[GRID_COLS-1] = (row_q == '0) && frozen_q;
  end

  // Grid write port: only the row under the scan pointer changes.
  always_comb begin
    grid_d = grid_q;
    if (state_q == ST_SCAN) begin
      grid_d[int'(row_q)*GRID_COLS +: GRID_COLS] = row_data_s;
    end else begin
      grid_d = grid_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_74a) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      row_q        <= '0;
      base_lat_q   <= '0;
      shadow_q     <= '0;
      grid_q       <= '0;
      frozen_q     <= 1'b0;
      page_q       <= '0;
      frame_done_q <= 1'b0;
      // Prev registers start high so a key held through reset is not a press.
      up_prev_q    <= 1'b1;
      down_prev_q  <= 1'b1;
      frz_prev_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      row_q        <= row_d;
      base_lat_q   <= base_lat_d;
      shadow_q     <= shadow_d;
      grid_q       <= grid_d;
      frozen_q     <= frozen_d;
      page_q       <= page_d;
      frame_done_q <= frame_done_d;
      up_prev_q    <= key_up;
      down_prev_q  <= key_down;
      frz_prev_q   <= key_freeze;
    end
  end

  assign grid_ram   = grid_q;
  assign frozen     = frozen_q;
  assign page_base  = page_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ngy_grid_probe_display.sv
// Directed bench for ngy_grid_probe_display: one default instance (8 channels)
// and one 40-channel instance for paging, sharing clock, reset and keys.

module tb_ngy_grid_probe_display;

  logic          clk;
  logic          reset_n;
  logic          key_up, key_down, key_freeze;
  logic [255:0]  probe_a;
  logic [1279:0] probe_b;
  logic [0:1199] grid_a, grid_b;
  logic          frozen_a, frozen_b;
  logic [2:0]    page_a;
  logic [5:0]    page_b;
  logic          done_a, done_b;

  int checks = 0;
  int errors = 0;

  ngy_grid_probe_display dut_a (
    .clk_74a(clk), .reset_n(reset_n), .probe_bus(probe_a),
    .key_up(key_up), .key_down(key_down), .key_freeze(key_freeze),
    .grid_ram(grid_a), .frozen(frozen_a), .page_base(page_a), .frame_done(done_a)
  );

  ngy_grid_probe_display #(.NUM_CH(40)) dut_b (
    .clk_74a(clk), .reset_n(reset_n), .probe_bus(probe_b),
    .key_up(key_up), .key_down(key_down), .key_freeze(key_freeze),
    .grid_ram(grid_b), .frozen(frozen_b), .page_base(page_b), .frame_done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One reset edge; on return we sit just after that edge.
  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic advance(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle key pulse followed by one idle cycle.
  task automatic press(input logic u, input logic d, input logic f);
    key_up = u; key_down = d; key_freeze = f;
    @(negedge clk);
    key_up = 1'b0; key_down = 1'b0; key_freeze = 1'b0;
    @(negedge clk);
  endtask

  // Advance until the next frame_done strobe, bounded.
  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done_a !== 1'b1 && n < 200);
    checks++;
    if (done_a !== 1'b1 || done_b !== 1'b1) begin
      errors++;
      $display("FAIL wait_done: frame_done a=%b b=%b after %0d cycles, required 1", done_a, done_b, n);
    end
  endtask

  task automatic test_reset();
    probe_a = '0;
    probe_a[31:0]  = 32'h54000008;
    probe_a[63:32] = 32'h00000001;
    for (int c = 0; c < 40; c++) probe_b[c*32 +: 32] = 32'hC0DE0000 + 32'(c);
    key_up = 1'b0; key_down = 1'b0; key_freeze = 1'b0;
    do_reset();
    checks++;
    if (grid_a !== '0 || grid_b !== '0) begin
      errors++; $display("FAIL reset_grid: grid not all zero, required 0");
    end
    checks++;
    if (frozen_a !== 1'b0 || page_a !== 3'd0 || done_a !== 1'b0 || page_b !== 6'd0) begin
      errors++;
      $display("FAIL reset_outs: frozen=%b page=%0d done=%b page_b=%0d, required 0 0 0 0",
               frozen_a, page_a, done_a, page_b);
    end
  endtask

  task automatic test_first_frame();
    advance(93);
    checks++;
    if (done_a !== 1'b0) begin
      errors++; $display("FAIL first_done_early: frame_done=%b after edge 93, required 0", done_a);
    end
    advance(1);
    checks++;
    if (done_a !== 1'b1) begin
      errors++; $display("FAIL first_done: frame_done=%b after edge 94, required 1", done_a);
    end
    checks++;
    if (grid_a[0:31] !== 32'h54000008) begin
      errors++; $display("FAIL first_row0: got %h required 54000008", grid_a[0:31]);
    end
    checks++;
    if (grid_a[40:71] !== 32'h00000001) begin
      errors++; $display("FAIL first_row1: got %h required 00000001", grid_a[40:71]);
    end
    checks++;
    if (grid_a[39] !== 1'b0) begin
      errors++; $display("FAIL first_marker: got %b required 0", grid_a[39]);
    end
    checks++;
    if (grid_a[320:1199] !== '0) begin
      errors++; $display("FAIL first_rows_8_29: nonzero pixels, required all 0");
    end
    checks++;
    if (grid_b[0:31] !== 32'hC0DE0000 || grid_b[1160:1191] !== 32'hC0DE001D) begin
      errors++;
      $display("FAIL first_b_rows: row0=%h row29=%h required c0de0000 c0de001d",
               grid_b[0:31], grid_b[1160:1191]);
    end
    advance(1);
    checks++;
    if (done_a !== 1'b0) begin
      errors++; $display("FAIL first_done_width: frame_done=%b after edge 95, required 0", done_a);
    end
  endtask

  task automatic test_freeze();
    press(1'b0, 1'b0, 1'b1);
    checks++;
    if (frozen_a !== 1'b1) begin
      errors++; $display("FAIL freeze_on: frozen=%b required 1", frozen_a);
    end
    probe_a[31:0] = 32'hFFFFFFFF;
    wait_done();
    checks++;
    if (grid_a[0:31] !== 32'h54000008 || grid_a[39] !== 1'b1) begin
      errors++;
      $display("FAIL freeze_hold: row0=%h marker=%b required 54000008 1", grid_a[0:31], grid_a[39]);
    end
    press(1'b0, 1'b0, 1'b1);
    checks++;
    if (frozen_a !== 1'b0) begin
      errors++; $display("FAIL freeze_off: frozen=%b required 0", frozen_a);
    end
    wait_done();
    checks++;
    if (grid_a[0:31] !== 32'hFFFFFFFF || grid_a[39] !== 1'b0) begin
      errors++;
      $display("FAIL unfreeze_show: row0=%h marker=%b required ffffffff 0", grid_a[0:31], grid_a[39]);
    end
  endtask

  task automatic test_paging();
    for (int i = 0; i < 15; i++) press(1'b0, 1'b1, 1'b0);
    checks++;
    if (page_b !== 6'd10 || page_a !== 3'd0) begin
      errors++; $display("FAIL page_sat_hi: b=%0d a=%0d required 10 0", page_b, page_a);
    end
    wait_done();
    wait_done();
    checks++;
    if (grid_b[0:31] !== 32'hC0DE000A || grid_b[1160:1191] !== 32'hC0DE0027) begin
      errors++;
      $display("FAIL page_rows: row0=%h row29=%h required c0de000a c0de0027",
               grid_b[0:31], grid_b[1160:1191]);
    end
    for (int i = 0; i < 12; i++) press(1'b1, 1'b0, 1'b0);
    checks++;
    if (page_b !== 6'd0) begin
      errors++; $display("FAIL page_sat_lo: got %0d required 0", page_b);
    end
    press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b1, 1'b0);
    checks++;
    if (page_b !== 6'd1) begin
      errors++; $display("FAIL page_both: got %0d required 1", page_b);
    end
    press(1'b1, 1'b0, 1'b0);
    checks++;
    if (page_b !== 6'd0) begin
      errors++; $display("FAIL page_up_one: got %0d required 0", page_b);
    end
  endtask

  task automatic test_key_held_reset();
    key_down = 1'b1;
    @(negedge clk);
    do_reset();
    advance(3);
    checks++;
    if (page_b !== 6'd0) begin
      errors++; $display("FAIL held_reset: page=%0d required 0", page_b);
    end
    key_down = 1'b0;
    advance(1);
    press(1'b0, 1'b1, 1'b0);
    checks++;
    if (page_b !== 6'd1) begin
      errors++; $display("FAIL held_repress: page=%0d required 1", page_b);
    end
  endtask

  task automatic test_midscan_page();
    do_reset();
    advance(69);
    key_down = 1'b1;
    @(negedge clk);
    key_down = 1'b0;
    checks++;
    if (page_b !== 6'd1) begin
      errors++; $display("FAIL midscan_page: page=%0d required 1", page_b);
    end
    wait_done();
    checks++;
    if (grid_b[0:31] !== 32'hC0DE0000 || grid_b[1160:1191] !== 32'hC0DE001D) begin
      errors++;
      $display("FAIL midscan_cur: row0=%h row29=%h required c0de0000 c0de001d",
               grid_b[0:31], grid_b[1160:1191]);
    end
    wait_done();
    checks++;
    if (grid_b[0:31] !== 32'hC0DE0001 || grid_b[1160:1191] !== 32'hC0DE001E) begin
      errors++;
      $display("FAIL midscan_next: row0=%h row29=%h required c0de0001 c0de001e",
               grid_b[0:31], grid_b[1160:1191]);
    end
  endtask

  task automatic test_reset_midscan();
    do_reset();
    advance(76);
    checks++;
    if (grid_a[0:31] !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL rst_mid_pre: row0=%h required ffffffff", grid_a[0:31]);
    end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checks++;
    if (grid_a !== '0 || grid_b !== '0 || done_a !== 1'b0 || page_b !== 6'd0) begin
      errors++;
      $display("FAIL rst_mid_clear: grid or outputs not cleared, done=%b page_b=%0d", done_a, page_b);
    end
    advance(93);
    checks++;
    if (done_a !== 1'b0) begin
      errors++; $display("FAIL rst_mid_early: frame_done=%b required 0", done_a);
    end
    advance(1);
    checks++;
    if (done_a !== 1'b1 || grid_a[0:31] !== 32'hFFFFFFFF || grid_a[40:71] !== 32'h00000001) begin
      errors++;
      $display("FAIL rst_mid_frame: done=%b row0=%h row1=%h required 1 ffffffff 00000001",
               done_a, grid_a[0:31], grid_a[40:71]);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    key_up = 1'b0; key_down = 1'b0; key_freeze = 1'b0;
    probe_a = '0;
    probe_b = '0;
    test_reset();
    test_first_frame();
    test_freeze();
    test_paging();
    test_key_held_reset();
    test_midscan_page();
    test_reset_midscan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
